// File: rtl/bs_uart_pkg.sv
// Shared definitions for the attack-word UART link (master TX and slave RX).
// Frame: SYNC, LO, HI, CHK where CHK = SYNC ^ LO ^ HI.
package bs_uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    F_SYNC,
    F_LO,
    F_HI,
    F_CHK
  } frame_state_t;

  function automatic logic [7:0] frame_chk(
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    return SYNC_BYTE ^ lo ^ hi;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer and mid-bit sampling FSM.
// Emits one-cycle byte_valid / byte_err pulses at the stop-bit sample.
module uart_rx_byte
  import bs_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       byte_busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  byte_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          valid_q;
  logic          err_q;
  logic          rx_meta_q;
  logic          rx_s_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= B_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        B_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s_q) state_q <= B_START;
        end
        B_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            // A start bit that is gone by mid-bit was a glitch.
            state_q <= rx_s_q ? B_IDLE : B_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= B_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        B_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            valid_q <= rx_s_q;
            err_q   <= !rx_s_q;
            state_q <= B_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= B_IDLE;
      endcase
    end
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign byte_err   = err_q;
  assign byte_busy  = (state_q != B_IDLE);

endmodule

// File: rtl/attack_uart_rx.sv
// Slave-side attack-word receiver: frames SYNC/LO/HI/CHK bytes into a
// checksummed 16-bit attack vector with inter-byte timeout.
module attack_uart_rx
  import bs_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int TIMEOUT_BITS = 30
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rx,
  output logic [15:0] attack,
  output logic        attack_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err;
  logic       byte_busy;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .clr       (clr),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .byte_busy (byte_busy)
  );

  frame_state_t  fstate_q;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;
  logic [TW-1:0] tcnt_q;
  logic [15:0]   attack_q;
  logic          av_q;
  logic          fe_q;
  logic          timeout_hit;

  assign timeout_hit = (fstate_q != F_SYNC) && !byte_busy &&
                       (tcnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      fstate_q <= F_SYNC;
      lo_q     <= '0;
      hi_q     <= '0;
      tcnt_q   <= '0;
      attack_q <= '0;
      av_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      av_q <= 1'b0;
      fe_q <= 1'b0;
      // Idle time only accrues mid-frame; any start bit restarts it.
      if (fstate_q == F_SYNC || byte_busy) tcnt_q <= '0;
      else tcnt_q <= tcnt_q + 1'b1;
      if (byte_err) begin
        fe_q     <= 1'b1;
        fstate_q <= F_SYNC;
      end else if (byte_valid) begin
        unique case (fstate_q)
          F_SYNC: if (byte_data == SYNC_BYTE) fstate_q <= F_LO;
          F_LO: begin
            lo_q     <= byte_data;
            fstate_q <= F_HI;
          end
          F_HI: begin
            hi_q     <= byte_data;
            fstate_q <= F_CHK;
          end
          F_CHK: begin
            if (byte_data == frame_chk(lo_q, hi_q)) begin
              attack_q <= {hi_q, lo_q};
              av_q     <= 1'b1;
            end else begin
              fe_q <= 1'b1;
            end
            fstate_q <= F_SYNC;
          end
          default: fstate_q <= F_SYNC;
        endcase
      end else if (timeout_hit) begin
        fe_q     <= 1'b1;
        fstate_q <= F_SYNC;
      end
    end
  end

  assign attack       = attack_q;
  assign attack_valid = av_q;
  assign frame_err    = fe_q;
  assign busy         = (fstate_q != F_SYNC) | byte_busy;

endmodule

// File: tb/tb_attack_uart_rx.sv
// Bench for attack_uart_rx: directed scenarios plus random frame streams
// checked against a byte-stream frame parser model.
module tb_attack_uart_rx;

  localparam int CPB = 16;
  localparam int TOB = 30;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] attack;
  logic        attack_valid;
  logic        frame_err;
  logic        busy;

  always #5 clk = ~clk;

  attack_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .rx          (rx),
    .attack      (attack),
    .attack_valid(attack_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_av = 0;
  int n_fe = 0;
  int n_both = 0;
  int last_fe_cyc = 0;
  int av0, fe0;
  logic [15:0] got_q[$];
  logic [7:0]  stream[$];
  logic [15:0] exp_q[$];
  int exp_err;

  always @(negedge clk) begin
    cyc++;
    if (attack_valid) begin
      n_av++;
      got_q.push_back(attack);
    end
    if (frame_err) begin
      n_fe++;
      last_fe_cyc = cyc;
    end
    if (attack_valid && frame_err) n_both++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int from, input int to);
    for (int i = from; i < to; i++) begin
      rx = b[i];
      idle(CPB);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    idle(CPB);
    send_bits(b, 0, 8);
    rx = stop;
    idle(CPB);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(lo);
    send_byte(hi);
    send_byte(chk);
  endtask

  task automatic snap();
    av0 = n_av;
    fe0 = n_fe;
    got_q.delete();
  endtask

  // Model: scan for SYNC, take the next three bytes as LO, HI, CHK.
  task automatic model_stream();
    int i;
    i = 0;
    exp_q.delete();
    exp_err = 0;
    while (i + 3 < stream.size()) begin
      if (stream[i] != 8'hA5) begin
        i++;
      end else begin
        if (stream[i+3] == (8'hA5 ^ stream[i+1] ^ stream[i+2]))
          exp_q.push_back({stream[i+2], stream[i+1]});
        else
          exp_err++;
        i += 4;
      end
    end
  endtask

  task automatic check_counts(input string nm, input int e_av, input int e_fe);
    n_chk++;
    if ((n_av - av0) !== e_av) begin
      n_fail++;
      $display("FAIL %s valid_pulses got=%0d exp=%0d", nm, n_av - av0, e_av);
    end
    n_chk++;
    if ((n_fe - fe0) !== e_fe) begin
      n_fail++;
      $display("FAIL %s err_pulses got=%0d exp=%0d", nm, n_fe - fe0, e_fe);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    rx = 1'b1;
    idle(3);
    clr = 1'b0;
    idle(1);
    n_chk++;
    if ({attack, attack_valid, frame_err, busy} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset outs got=%h/%b%b%b exp=0000/000",
               attack, attack_valid, frame_err, busy);
    end
    idle(5);
  endtask

  task automatic test_good_frame();
    snap();
    send_frame(8'h34, 8'h12, 8'h83);
    idle(4);
    check_counts("good_frame", 1, 0);
    n_chk++;
    if (attack !== 16'h1234) begin
      n_fail++;
      $display("FAIL good_frame attack got=%h exp=1234", attack);
    end
  endtask

  task automatic test_bad_chk();
    snap();
    send_frame(8'h34, 8'h12, 8'h00);
    idle(4);
    check_counts("bad_chk", 0, 1);
    n_chk++;
    if (attack !== 16'h1234) begin
      n_fail++;
      $display("FAIL bad_chk attack got=%h exp=1234", attack);
    end
  endtask

  task automatic test_glitch();
    snap();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check_counts("glitch", 0, 0);
    n_chk++;
    if ({busy, attack} !== {1'b0, 16'h1234}) begin
      n_fail++;
      $display("FAIL glitch busy/attack got=%b/%h exp=0/1234", busy, attack);
    end
  endtask

  task automatic test_stop_err();
    snap();
    send_byte(8'hA5);
    send_byte(8'h34, 1'b0);
    idle(12 * CPB);
    check_counts("stop_err", 0, 1);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_err busy got=%b exp=0", busy);
    end
    snap();
    send_frame(8'hFF, 8'h00, 8'h5A);
    idle(4);
    check_counts("recover", 1, 0);
    n_chk++;
    if (attack !== 16'h00FF) begin
      n_fail++;
      $display("FAIL recover attack got=%h exp=00ff", attack);
    end
  endtask

  task automatic test_junk_timeout();
    int t0;
    snap();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h01, 8'h80, 8'h24);
    idle(4);
    check_counts("junk", 1, 0);
    n_chk++;
    if (attack !== 16'h8001) begin
      n_fail++;
      $display("FAIL junk attack got=%h exp=8001", attack);
    end
    snap();
    send_byte(8'hA5);
    t0 = cyc;
    idle(500);
    check_counts("timeout", 0, 1);
    n_chk++;
    if ((last_fe_cyc - t0) < TOB * CPB - 10 ||
        (last_fe_cyc - t0) > TOB * CPB + 10) begin
      n_fail++;
      $display("FAIL timeout idle_cycles got=%0d exp=%0d+-10",
               last_fe_cyc - t0, TOB * CPB);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_clr_mid();
    logic [7:0] hi;
    hi = 8'h12;
    snap();
    send_byte(8'hA5);
    send_byte(8'h34);
    rx = 1'b0;
    idle(CPB);
    send_bits(hi, 0, 5);
    rx = hi[5];
    idle(CPB / 2);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    n_chk++;
    if ({attack, busy, attack_valid, frame_err} !== 19'h0) begin
      n_fail++;
      $display("FAIL clr_mid outs got=%h/%b%b%b exp=0000/000",
               attack, busy, attack_valid, frame_err);
    end
    idle(CPB / 2 - 1);
    send_bits(hi, 6, 8);
    rx = 1'b1;
    idle(CPB);
    idle(12 * CPB);
    check_counts("clr_mid", 0, 0);
    snap();
    send_frame(8'h34, 8'h12, 8'h83);
    idle(4);
    check_counts("after_clr", 1, 0);
    n_chk++;
    if (attack !== 16'h1234) begin
      n_fail++;
      $display("FAIL after_clr attack got=%h exp=1234", attack);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    send_frame(8'h11, 8'h22, 8'hA5 ^ 8'h11 ^ 8'h22);
    send_frame(8'h33, 8'h44, 8'hA5 ^ 8'h33 ^ 8'h44);
    idle(4);
    check_counts("b2b", 2, 0);
    n_chk++;
    if (got_q.size() != 2 || got_q[0] !== 16'h2211 || got_q[1] !== 16'h4433) begin
      n_fail++;
      $display("FAIL b2b words got_n=%0d exp=2211,4433", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] lo, hi, chk, junk;
    snap();
    stream.delete();
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        stream.push_back(junk);
      end
      lo = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 255));
      chk = 8'hA5 ^ lo ^ hi;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      stream.push_back(8'hA5);
      stream.push_back(lo);
      stream.push_back(hi);
      stream.push_back(chk);
    end
    foreach (stream[k]) begin
      send_byte(stream[k]);
      idle($urandom_range(0, 3 * CPB));
    end
    idle(4);
    model_stream();
    check_counts("random", exp_q.size(), exp_err);
    for (int k = 0; k < exp_q.size(); k++) begin
      n_chk++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL random word%0d got=%h exp=%h", k,
                 (k < got_q.size()) ? got_q[k] : 16'hxxxx, exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_glitch();
    test_stop_err();
    test_junk_timeout();
    test_clr_mid();
    test_back_to_back();
    test_random();
    n_chk++;
    if (n_both !== 0) begin
      n_fail++;
      $display("FAIL exclusive both_pulses got=%0d exp=0", n_both);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
